// File: rtl/t_flip_flop.sv
// Bank of independent synchronous T flip-flops with a complemented output
// and a one-cycle "toggled" flag per bit.

module t_flip_flop_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic t,
  input  logic rst_val,
  output logic q,
  output logic toggled
);

  logic q_q, q_d;
  logic tog_q, tog_d;

  always_comb begin
    q_d   = q_q;
    tog_d = 1'b0;
    if (!rst) begin
      q_d   = rst_val;
      tog_d = 1'b0;
    end else if (en) begin
      q_d   = q_q ^ t;
      tog_d = t;
    end
  end

  always_ff @(posedge clk) begin
    q_q   <= q_d;
    tog_q <= tog_d;
  end

  assign q       = q_q;
  assign toggled = tog_q;

endmodule

module t_flip_flop #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] toggled
);

  // Bits never interact, so each one is its own lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    t_flip_flop_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .t       (t[i]),
      .rst_val (RST_VAL[i]),
      .q       (q[i]),
      .toggled (toggled[i])
    );
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench: WIDTH=1 vector table, WIDTH=4 enable/reset sequence,
// then randomized WIDTH=4 traffic against a simple reference model.

module tb_t_flip_flop;

  logic       clk = 1'b0;
  logic       rst1, en1, t1;
  logic       q1, qn1, tog1;
  logic       rst4, en4;
  logic [3:0] t4, q4, qn4, tog4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  t_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .t(t1),
    .q(q1), .q_n(qn1), .toggled(tog1)
  );

  t_flip_flop #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .t(t4),
    .q(q4), .q_n(qn4), .toggled(tog4)
  );

  typedef struct {
    logic rst;
    logic en;
    logic t;
    logic exp_q;
    logic exp_tog;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic tt, input logic eq, input logic et);
    vec_t v;
    v.rst = r; v.en = e; v.t = tt; v.exp_q = eq; v.exp_tog = et;
    vecs.push_back(v);
  endtask

  task automatic step4(input logic r, input logic e, input logic [3:0] tt);
    rst4 = r; en4 = e; t4 = tt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] mq, mtog;
    rst1 = 1'b1; en1 = 1'b1; t1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b1; t4 = 4'b0;

    // rst en t  q tog
    add(0, 1, 0, 0, 0);  // reset
    add(0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1);  // toggle 0->1->0
    add(1, 1, 1, 0, 1);
    add(1, 1, 1, 1, 1);  // to q=1
    add(1, 1, 0, 1, 0);  // hold x3
    add(1, 1, 0, 1, 0);
    add(1, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1);  // back to 0
    add(1, 1, 1, 1, 1);  // alternating 1,0,1
    add(1, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1);
    add(1, 1, 1, 1, 1);  // to q=1
    add(0, 1, 1, 0, 0);  // reset mid-op, t ignored
    add(0, 1, 1, 0, 0);
    add(1, 1, 1, 1, 1);  // resume from RST_VAL
    add(1, 1, 1, 0, 1);
    add(1, 0, 1, 0, 0);  // en=0 holds
    add(0, 0, 1, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst1 = vecs[i].rst; en1 = vecs[i].en; t1 = vecs[i].t;
      @(posedge clk);
      #1;
      chk($sformatf("w1_q[%0d]", i), {31'b0, q1}, {31'b0, vecs[i].exp_q});
      chk($sformatf("w1_qn[%0d]", i), {31'b0, qn1}, {31'b0, ~vecs[i].exp_q});
      chk($sformatf("w1_tog[%0d]", i), {31'b0, tog1}, {31'b0, vecs[i].exp_tog});
    end

    // WIDTH=4 enable and reset value
    step4(0, 1, 4'b1111);
    chk("w4_rst_q", {28'b0, q4}, 32'hA);
    chk("w4_rst_qn", {28'b0, qn4}, 32'h5);
    chk("w4_rst_tog", {28'b0, tog4}, 32'h0);
    step4(1, 0, 4'b1111);
    chk("w4_en0_q", {28'b0, q4}, 32'hA);
    chk("w4_en0_tog", {28'b0, tog4}, 32'h0);
    step4(1, 1, 4'b0110);
    chk("w4_tog_q", {28'b0, q4}, 32'hC);
    chk("w4_tog_tog", {28'b0, tog4}, 32'h6);
    chk("w4_tog_qn", {28'b0, qn4}, 32'h3);

    // Randomized traffic: model is just "flip the requested bits when enabled"
    mq = 4'hC;
    for (int c = 0; c < 300; c++) begin
      logic r, e;
      logic [3:0] tt;
      r  = ($urandom_range(0, 9) != 0);
      e  = ($urandom_range(0, 3) != 0);
      tt = 4'($urandom);
      if (!r) begin
        mq = 4'b1010; mtog = 4'b0;
      end else if (e) begin
        mq = mq ^ tt; mtog = tt;
      end else begin
        mtog = 4'b0;
      end
      step4(r, e, tt);
      chk($sformatf("rnd_q[%0d]", c), {28'b0, q4}, {28'b0, mq});
      chk($sformatf("rnd_qn[%0d]", c), {28'b0, qn4}, {28'b0, ~mq});
      chk($sformatf("rnd_tog[%0d]", c), {28'b0, tog4}, {28'b0, mtog});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
